// File: rtl/cs_pkg.sv
// Shared types, default parameters and width helpers for the cs_window smoother.
package cs_pkg;

    typedef enum logic {
        CS_MODE_LE_AVG = 1'b0,
        CS_MODE_GE_AVG = 1'b1
    } cs_mode_e;

    localparam int CS_DEF_W     = 8;
    localparam int CS_DEF_N     = 9;
    localparam int CS_DEF_SHIFT = 3;
    localparam int CS_DEF_YW    = 10;

    // Running-sum width: holds N full-scale samples.
    function automatic int cs_sum_w(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // The largest output (sum and N*Xappr both at full scale) must fit in YW bits.
    function automatic bit cs_yw_ok(input int w, input int n, input int shift, input int yw);
        longint peak;
        peak = (longint'(2 * n) * ((longint'(1) << w) - 1)) >>> shift;
        if (yw >= 62) begin
            return 1'b1;
        end
        return (peak >>> yw) == 0;
    endfunction

endpackage

// File: rtl/cs_select.sv
// Divider-free approximation select: N parallel scaled comparisons against the
// window sum, then a balanced max (mode 0) or min (mode 1) reduction tree.
module cs_select
    import cs_pkg::*;
#(
    parameter int W  = CS_DEF_W,
    parameter int N  = CS_DEF_N,
    parameter int SW = cs_sum_w(CS_DEF_W, CS_DEF_N)
) (
    input  logic [W-1:0]  win_i [N],
    input  logic [SW-1:0] sum_i,
    input  cs_mode_e      mode_i,
    output logic [W-1:0]  xappr_o
);

    localparam int LW = $clog2(N);
    localparam int P  = 1 << LW;

    // Heap-ordered tree: leaves at P..2P-1, root at 1.
    logic [W-1:0] node [1:2*P-1];
    logic [W-1:0] pad;
    logic         ge_mode;

    assign ge_mode = (mode_i == CS_MODE_GE_AVG);
    // Non-qualifiers are replaced by the reduction's identity so they never win.
    assign pad     = ge_mode ? {W{1'b1}} : {W{1'b0}};

    genvar gi;
    for (gi = 0; gi < P; gi++) begin : g_leaf
        if (gi < N) begin : g_cmp
            logic [SW-1:0] scaled;
            logic          qual;
            assign scaled = SW'(N) * SW'(win_i[gi]);
            assign qual   = ge_mode ? (scaled >= sum_i) : (scaled <= sum_i);
            assign node[P+gi] = qual ? win_i[gi] : pad;
        end else begin : g_pad
            assign node[P+gi] = pad;
        end
    end

    for (gi = 1; gi < P; gi++) begin : g_tree
        logic a_lt_b;
        assign a_lt_b   = node[2*gi] < node[2*gi+1];
        assign node[gi] = (ge_mode == a_lt_b) ? node[2*gi] : node[2*gi+1];
    end

    assign xappr_o = node[1];

endmodule

// File: rtl/cs_window.sv
// Sliding-window smoother: N-deep sample window with running sum and fill count,
// followed by one registered output stage Y = (sum + N*Xappr) >> SHIFT.
module cs_window
    import cs_pkg::*;
#(
    parameter int W     = CS_DEF_W,
    parameter int N     = CS_DEF_N,
    parameter int SHIFT = CS_DEF_SHIFT,
    parameter int YW    = CS_DEF_YW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  X,
    input  logic          mode,
    input  logic          flush,
    output logic          out_valid,
    output logic [YW-1:0] Y
);

    localparam int SW = cs_sum_w(W, N);
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * SW;

    if (N < 2 || N > 64 || !cs_yw_ok(W, N, SHIFT, YW)) begin : g_bad_cfg
        $error("cs_window: illegal N or YW too narrow for W/N/SHIFT");
    end

    logic [W-1:0]  win_q [N];
    logic [W-1:0]  win_d [N];
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] count_q, count_d;
    cs_mode_e      mode_q, mode_d;
    logic          pend_q, pend_d;
    logic          out_valid_q, out_valid_d;
    logic [YW-1:0] y_q, y_d;

    logic          full;
    logic [W-1:0]  xappr;
    logic [AW-1:0] acc;

    assign full = (count_q == CW'(N));

    always_comb begin
        win_d   = win_q;
        sum_d   = sum_q;
        count_d = count_q;
        mode_d  = mode_q;
        pend_d  = 1'b0;
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                win_d[i] = '0;
            end
            sum_d   = '0;
            count_d = '0;
            // A sample arriving with the flush starts the fresh window.
            if (in_valid) begin
                win_d[0] = X;
                sum_d    = SW'(X);
                count_d  = CW'(1);
                mode_d   = cs_mode_e'(mode);
            end
        end else if (in_valid) begin
            for (int i = N - 1; i > 0; i--) begin
                win_d[i] = win_q[i-1];
            end
            win_d[0] = X;
            sum_d    = sum_q + SW'(X) - (full ? SW'(win_q[N-1]) : SW'(0));
            count_d  = full ? count_q : count_q + CW'(1);
            mode_d   = cs_mode_e'(mode);
            pend_d   = full || (count_q == CW'(N - 1));
        end
    end

    cs_select #(
        .W  (W),
        .N  (N),
        .SW (SW)
    ) u_select (
        .win_i   (win_q),
        .sum_i   (sum_q),
        .mode_i  (mode_q),
        .xappr_o (xappr)
    );

    // Output stage works from the registered window, so a flush now still kills
    // the result of the previous accept.
    assign acc         = AW'(sum_q) + AW'(N) * AW'(xappr);
    assign out_valid_d = pend_q && !flush;
    assign y_d         = out_valid_d ? YW'(acc >> SHIFT) : y_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            count_q     <= '0;
            mode_q      <= CS_MODE_LE_AVG;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;

endmodule
